// File: rtl/priority_arbiter_if.sv
// Request/grant bundle between requesters and priority_arbiter.
//   I_Req     : request vector, one bit per requester
//   I_Rls     : release strobe from the current owner
//   O_Grt     : binary index of the current owner
//   O_GrtOH   : one-hot grant, all zero when idle
//   O_Vld     : grant valid
//   O_Timeout : one-cycle pulse on a forced release
// master = requester side, slave = arbiter side.
interface priority_arbiter_if #(
    parameter int unsigned NUM_ENTRY = 20
);
    localparam int unsigned IW = (NUM_ENTRY > 1) ? $clog2(NUM_ENTRY) : 1;

    logic [NUM_ENTRY-1:0] I_Req;
    logic                 I_Rls;
    logic [IW-1:0]        O_Grt;
    logic [NUM_ENTRY-1:0] O_GrtOH;
    logic                 O_Vld;
    logic                 O_Timeout;

    modport master (
        output I_Req, I_Rls,
        input  O_Grt, O_GrtOH, O_Vld, O_Timeout
    );

    modport slave (
        input  I_Req, I_Rls,
        output O_Grt, O_GrtOH, O_Vld, O_Timeout
    );
endinterface

// File: rtl/priority_arbiter.sv
// Registered, lock-holding arbiter: fixed priority (index 0 highest) or
// round-robin. A grant is held until the owner releases it or drops its
// request; on release the next winner is registered with no bubble.
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : priority_arbiter_if.slave (I_Req, I_Rls in; O_Grt, O_GrtOH,
//           O_Vld, O_Timeout out, all registered)
// Optional feature macro: ARBITER_LOCK_TIMEOUT_EN -- forces a release after
// LOCK_TIMEOUT grant cycles and pulses O_Timeout; otherwise O_Timeout is 0.
module priority_arbiter #(
    parameter int unsigned NUM_ENTRY    = 20,
    parameter int unsigned RR_MODE      = 1,
    parameter int unsigned LOCK_TIMEOUT = 16
) (
    input  logic               clock,
    input  logic               reset,
    priority_arbiter_if.slave  bus
);
    localparam int unsigned IW = (NUM_ENTRY > 1) ? $clog2(NUM_ENTRY) : 1;

    if (NUM_ENTRY < 2 || LOCK_TIMEOUT < 1) begin : g_param_check
        $error("priority_arbiter: NUM_ENTRY must be >= 2 and LOCK_TIMEOUT >= 1");
    end

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        grt_q, grt_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [NUM_ENTRY-1:0] oh_q, oh_d;
    logic                 vld_q, vld_d;

    logic                 forced_c;
    logic                 release_c;
    logic [IW-1:0]        ptr_next_c;
    logic [IW-1:0]        arb_ptr_c;
    logic [NUM_ENTRY-1:0] arb_req_c;
    logic [NUM_ENTRY-1:0] rot_c;
    logic [IW:0]          sum_c;
    logic [IW-1:0]        win_c;
    logic                 win_found_c;

`ifdef ARBITER_LOCK_TIMEOUT_EN
    localparam int unsigned CW = $clog2(LOCK_TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tmo_q, tmo_d;

    assign forced_c = (cnt_q == CW'(LOCK_TIMEOUT - 1));
`else
    assign forced_c = 1'b0;
`endif

    // Release in this cycle: strobe, owner dropped its request, or forced.
    assign release_c  = (state_q == GRANT) &&
                        (bus.I_Rls || !bus.I_Req[grt_q] || forced_c);
    assign ptr_next_c = (grt_q == IW'(NUM_ENTRY - 1)) ? '0 : grt_q + IW'(1);

    // Arbitration input: in GRANT the owner is masked and the updated pointer
    // is used, so a handoff never picks the releasing requester.
    assign arb_req_c = (state_q == GRANT) ?
                       (bus.I_Req & ~(NUM_ENTRY'(1) << grt_q)) : bus.I_Req;
    assign arb_ptr_c = (state_q == GRANT && RR_MODE != 0) ? ptr_next_c : ptr_q;

    // Rotate so the pointer sits at bit 0, take the lowest set bit, unrotate.
    always_comb begin
        rot_c       = NUM_ENTRY'({arb_req_c, arb_req_c} >> arb_ptr_c);
        win_found_c = 1'b0;
        sum_c       = '0;
        for (int unsigned i = 0; i < NUM_ENTRY; i++) begin
            if (!win_found_c && rot_c[i]) begin
                win_found_c = 1'b1;
                sum_c       = {1'b0, arb_ptr_c} + (IW+1)'(i);
            end
        end
        if (sum_c >= (IW+1)'(NUM_ENTRY)) begin
            sum_c = sum_c - (IW+1)'(NUM_ENTRY);
        end
        win_c = IW'(sum_c);
    end

    // Next-state and registered output values.
    always_comb begin
        state_d = state_q;
        grt_d   = grt_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (win_found_c) begin
                    state_d = GRANT;
                    grt_d   = win_c;
                end
            end
            GRANT: begin
                if (release_c) begin
                    if (RR_MODE != 0) begin
                        ptr_d = ptr_next_c;
                    end
                    if (win_found_c) begin
                        grt_d = win_c;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
        endcase
        vld_d = (state_d == GRANT);
        oh_d  = vld_d ? (NUM_ENTRY'(1) << grt_d) : '0;
    end

`ifdef ARBITER_LOCK_TIMEOUT_EN
    // Hold counter: cleared on each new grant, advances while the grant holds.
    always_comb begin
        cnt_d = '0;
        if (state_q == GRANT && !release_c) begin
            cnt_d = cnt_q + CW'(1);
        end
        tmo_d = (state_d == GRANT) && (cnt_d == CW'(LOCK_TIMEOUT - 1));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end

    assign bus.O_Timeout = tmo_q;
`else
    assign bus.O_Timeout = 1'b0;
`endif

    // State and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            grt_q   <= '0;
            ptr_q   <= '0;
            oh_q    <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grt_q   <= grt_d;
            ptr_q   <= ptr_d;
            oh_q    <= oh_d;
            vld_q   <= vld_d;
        end
    end

    assign bus.O_Grt   = grt_q;
    assign bus.O_GrtOH = oh_q;
    assign bus.O_Vld   = vld_q;
endmodule

// File: tb/tb_priority_arbiter.sv
// Self-checking bench for priority_arbiter: a fixed-priority and a
// round-robin instance see the same stimulus and are compared every cycle
// against a behavioural model of the arbitration rules.
module tb_priority_arbiter;
    localparam int unsigned N     = 20;
    localparam int unsigned IW    = $clog2(N);
    localparam int unsigned TB_LT = 4;

    logic clock = 1'b0;
    logic reset;
    logic [N-1:0] req;
    logic rls;

    always #5 clock = ~clock;

    priority_arbiter_if #(.NUM_ENTRY(N)) fx_if ();
    priority_arbiter_if #(.NUM_ENTRY(N)) rr_if ();

    assign fx_if.I_Req = req;
    assign fx_if.I_Rls = rls;
    assign rr_if.I_Req = req;
    assign rr_if.I_Rls = rls;

    priority_arbiter #(.NUM_ENTRY(N), .RR_MODE(0), .LOCK_TIMEOUT(TB_LT)) u_fx (
        .clock (clock),
        .reset (reset),
        .bus   (fx_if.slave)
    );

    priority_arbiter #(.NUM_ENTRY(N), .RR_MODE(1), .LOCK_TIMEOUT(TB_LT)) u_rr (
        .clock (clock),
        .reset (reset),
        .bus   (rr_if.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model state, index 0 = fixed priority, 1 = round-robin.
    bit m_vld [2];
    int m_grt [2];
    int m_ptr [2];
    int m_cnt [2];

    function automatic int pick(logic [N-1:0] r, int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_vld[m] = 1'b0;
            m_grt[m] = 0;
            m_ptr[m] = 0;
            m_cnt[m] = 0;
        end
    endtask

    task automatic model_step(int m, logic [N-1:0] r, logic s);
        int w;
        bit forced;
        logic [N-1:0] rest;
        forced = 1'b0;
`ifdef ARBITER_LOCK_TIMEOUT_EN
        forced = (m_cnt[m] == TB_LT - 1);
`endif
        if (!m_vld[m]) begin
            w = pick(r, m_ptr[m]);
            if (w >= 0) begin
                m_vld[m] = 1'b1;
                m_grt[m] = w;
                m_cnt[m] = 0;
            end
        end else if (s || !r[m_grt[m]] || forced) begin
            rest = r;
            rest[m_grt[m]] = 1'b0;
            if (m == 1) m_ptr[m] = (m_grt[m] + 1) % N;
            w = pick(rest, m_ptr[m]);
            if (w >= 0) begin
                m_grt[m] = w;
                m_cnt[m] = 0;
            end else begin
                m_vld[m] = 1'b0;
            end
        end else begin
            m_cnt[m]++;
        end
    endtask

    task automatic check_dut(string tag, int m, logic vld, logic [IW-1:0] grt,
                             logic [N-1:0] oh, logic tmo);
        logic [N-1:0] exp_oh;
        logic exp_tmo;
        exp_oh = '0;
        exp_tmo = 1'b0;
        if (m_vld[m]) exp_oh[m_grt[m]] = 1'b1;
`ifdef ARBITER_LOCK_TIMEOUT_EN
        exp_tmo = m_vld[m] && (m_cnt[m] == TB_LT - 1);
`endif
        n_cmp++;
        assert (vld === 1'(m_vld[m])) else begin
            n_err++;
            $error("FAIL %s[%0d] O_Vld got %0b want %0b", tag, m, vld, m_vld[m]);
        end
        n_cmp++;
        assert (oh === exp_oh) else begin
            n_err++;
            $error("FAIL %s[%0d] O_GrtOH got %h want %h", tag, m, oh, exp_oh);
        end
        n_cmp++;
        assert (tmo === exp_tmo) else begin
            n_err++;
            $error("FAIL %s[%0d] O_Timeout got %0b want %0b", tag, m, tmo, exp_tmo);
        end
        if (m_vld[m]) begin
            n_cmp++;
            assert (grt === IW'(m_grt[m])) else begin
                n_err++;
                $error("FAIL %s[%0d] O_Grt got %0d want %0d", tag, m, grt, m_grt[m]);
            end
        end
    endtask

    task automatic check_all(string tag);
        check_dut(tag, 0, fx_if.O_Vld, fx_if.O_Grt, fx_if.O_GrtOH, fx_if.O_Timeout);
        check_dut(tag, 1, rr_if.O_Vld, rr_if.O_Grt, rr_if.O_GrtOH, rr_if.O_Timeout);
    endtask

    // Called at a falling edge: drive, let the rising edge happen, check.
    task automatic cycle(logic [N-1:0] r, logic s, string tag);
        req = r;
        rls = s;
        @(posedge clock);
        if (reset) begin
            model_step(0, r, s);
            model_step(1, r, s);
        end
        @(negedge clock);
        check_all(tag);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req   = '0;
        rls   = 1'b0;
        model_reset();
        @(negedge clock);
        check_all("reset");
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        req   = '0;
        rls   = 1'b0;
        model_reset();
        @(negedge clock);
        @(negedge clock);
        check_all("por");
        reset = 1'b1;
        cycle('0, 1'b0, "idle");
        cycle('0, 1'b1, "idle_rls");

        // Fixed-priority hold: owner 1 keeps the grant after bit 0 rises.
        cycle(N'(20'h00012), 1'b0, "fx_first");
        for (int c = 0; c < 10; c++) cycle(N'(20'h00013), 1'b0, "fx_hold");
        cycle('0, 1'b0, "fx_drop");

        // Round-robin sweep with zero-bubble handoff and 19->0 wrap.
        do_reset();
        for (int c = 0; c < 66; c++) cycle('1, (c % 3) == 2, "rr_sweep");

        // Sole requester releases: one idle cycle, then re-grant.
        do_reset();
        cycle(N'(1) << 5, 1'b0, "solo_grant");
        cycle(N'(1) << 5, 1'b0, "solo_hold");
        cycle(N'(1) << 5, 1'b1, "solo_rls");
        cycle(N'(1) << 5, 1'b0, "solo_regrant");
        cycle(N'(1) << 5, 1'b0, "solo_hold2");

        // Owner drops its request while another waits.
        do_reset();
        cycle(N'(1) << 3, 1'b0, "drop_grant3");
        cycle(N'(1) << 7, 1'b0, "drop_hand7");
        cycle(N'(1) << 7, 1'b0, "drop_hold7");

        // Asynchronous reset between clock edges while a grant is held.
        cycle(N'(1) << 7, 1'b0, "pre_async");
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        @(negedge clock);
        reset = 1'b1;
        cycle(N'(20'h80000), 1'b0, "post_rst19");
        cycle(N'(20'h80000), 1'b1, "rls19");
        cycle(N'(20'h00001), 1'b0, "after19");

        // Randomized traffic.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            cycle(N'($urandom) & N'($urandom) & N'($urandom),
                  $urandom_range(3) == 0, "random");
        end

        // Long hold with no release (forced release only with the macro).
        do_reset();
        for (int c = 0; c < 100; c++) cycle(N'(20'h00003), 1'b0, "long_hold");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
